// File: rtl/vga_timing_gen_if.sv
// Video bus between a timing generator and the display path.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator; all outputs registered
// one cycle behind the h/v counters, start/stop and pattern changes on frame boundaries.
module vga_timing_gen #(
  parameter int unsigned HDISP     = 800,
  parameter int unsigned VDISP     = 480,
  parameter int unsigned HFP       = 40,
  parameter int unsigned HPULSE    = 48,
  parameter int unsigned HBP       = 40,
  parameter int unsigned VFP       = 13,
  parameter int unsigned VPULSE    = 3,
  parameter int unsigned VBP       = 29,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0,
  parameter int unsigned GRID_LOG2 = 4
) (
  input  logic                       pixel_clk,
  input  logic                       pixel_rst,
  input  logic                       run,
  input  logic [1:0]                 mode,
  input  logic [23:0]                solid_rgb,
  video_if.master                    video_ifm,
  output logic [$clog2(HDISP)-1:0]   x_pos,
  output logic [$clog2(VDISP)-1:0]   y_pos,
  output logic                       frame_start,
  output logic                       line_start
);

  localparam int unsigned HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int unsigned VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);
  localparam int unsigned XW     = $clog2(HDISP);
  localparam int unsigned YW     = $clog2(VDISP);
  localparam int unsigned BAR_W  = (HDISP / 8 == 0) ? 1 : HDISP / 8;

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_ACT0  = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_ACT0  = VW'(VFP + VPULSE + VBP);
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_mode;
  logic [23:0]   r_solid;
  logic [2:0]    r_bar_idx;
  logic [XW-1:0] r_bar_pix;

  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [23:0]   r_rgb;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_fs;
  logic          r_ls;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_act;
  logic [XW-1:0] w_hx;
  logic [YW-1:0] w_vy;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_rgb;

  always_comb begin
    w_h_last = (r_h == H_LAST);
    w_v_last = (r_v == V_LAST);
    w_hs_act = (r_h >= H_SYNC0) && (r_h < H_SYNC1);
    w_vs_act = (r_v >= V_SYNC0) && (r_v < V_SYNC1);
    w_act    = (r_h >= H_ACT0) && (r_v >= V_ACT0);
    w_hx     = XW'(r_h - H_ACT0);
    w_vy     = YW'(r_v - V_ACT0);

    case (r_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      default: w_bar_rgb = 24'h000000;
    endcase

    w_rgb = '0;
    case (r_mode)
      2'd0: if (w_hx[GRID_LOG2-1:0] == '0 || w_vy[GRID_LOG2-1:0] == '0) w_rgb = '1;
      2'd1: w_rgb = w_bar_rgb;
      2'd2: if (w_hx[GRID_LOG2] ^ w_vy[GRID_LOG2]) w_rgb = '1;
      default: w_rgb = r_solid;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_state   <= S_IDLE;
      r_h       <= '0;
      r_v       <= '0;
      r_mode    <= '0;
      r_solid   <= '0;
      r_bar_idx <= '0;
      r_bar_pix <= '0;
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_blank   <= 1'b0;
      r_rgb     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_fs      <= 1'b0;
      r_ls      <= 1'b0;
    end else begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_blank <= 1'b0;
      r_rgb   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Idling counts as a frame boundary, so the shadows track the inputs.
          r_mode  <= mode;
          r_solid <= solid_rgb;
          if (run) r_state <= S_RUN;
        end
        default: begin
          r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
          r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
          r_blank <= w_act;
          r_rgb   <= w_act ? w_rgb : '0;
          r_x     <= w_act ? w_hx : '0;
          r_y     <= w_act ? w_vy : '0;
          r_fs    <= (r_h == '0) && (r_v == '0);
          r_ls    <= (r_h == '0);

          // Bar index tracks the column with a run-length counter instead of a divider.
          if (r_h < H_ACT0 || w_h_last) begin
            r_bar_idx <= '0;
            r_bar_pix <= '0;
          end else if (r_bar_pix == BAR_LAST) begin
            r_bar_pix <= '0;
            if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
          end else begin
            r_bar_pix <= r_bar_pix + 1'b1;
          end

          if (w_h_last) begin
            r_h <= '0;
            if (w_v_last) begin
              r_v     <= '0;
              r_mode  <= mode;
              r_solid <= solid_rgb;
              if (!run) r_state <= S_IDLE;
            end else begin
              r_v <= r_v + 1'b1;
            end
          end else begin
            r_h <= r_h + 1'b1;
          end
        end
      endcase
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = r_hs;
  assign video_ifm.VS    = r_vs;
  assign video_ifm.BLANK = r_blank;
  assign video_ifm.RGB   = r_rgb;
  assign x_pos           = r_x;
  assign y_pos           = r_y;
  assign frame_start     = r_fs;
  assign line_start      = r_ls;

endmodule
